// File: rtl/mbr_pkg.sv
// Shared parameters, state encoding and parity helper for the word serializer.
// MBR_PARITY_EN adds one odd-parity slot after each word's data bits.
package mbr_pkg;

  localparam int WORD_W      = 12;
  localparam int FRAME_WORDS = 32;
  localparam int IDX_W       = $clog2(FRAME_WORDS);

  localparam logic [WORD_W-1:0] SYNC_WORD = 12'hE2B;
  localparam logic [WORD_W-1:0] FILL_WORD = 12'h000;
  localparam logic              IDLE_BIT  = 1'b1;

`ifdef MBR_PARITY_EN
  localparam int BCNT_W = $clog2(WORD_W + 1);
`else
  localparam int BCNT_W = $clog2(WORD_W);
`endif

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    PAD       = 2'd2
  } mbr_state_e;

  // Bit that makes the total count of ones (word plus parity) odd.
  function automatic logic odd_parity(input logic [WORD_W-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/mbr_edge_det.sv
// Rising-edge detector: one-cycle pulse when sig goes 0->1 relative to the
// previous clk sample. Synchronous active-low reset.
module mbr_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q_r;

  // Previous-sample register for sig.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig;
    end
  end

  assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/mbr_word_serializer.sv
// Serial telemetry word serializer: one bit per i320 slot, word loads on skut40,
// sync word at index 0. Optional parity slot under MBR_PARITY_EN.
module mbr_word_serializer
  import mbr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i320,
  input  logic              skut40,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              underflow_clr,
  output logic              sdata_o,
  output logic              frame_o,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic              underflow_o
);

  mbr_state_e        state_r, state_s;
  logic [WORD_W-1:0] shreg_r, shreg_s;
  logic [BCNT_W-1:0] bitcnt_r, bitcnt_s;
  logic              sdata_r, sdata_s;
  logic              frame_r, frame_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic              uf_r, uf_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic              load_data_s;
  logic              slot_s;
`ifdef MBR_PARITY_EN
  logic              par_r, par_s;
`endif

  mbr_edge_det u_slot_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (i320),
    .rise (slot_s)
  );

  assign next_idx_s  = (idx_r == IDX_W'(FRAME_WORDS - 1)) ? {IDX_W{1'b0}}
                                                          : idx_r + IDX_W'(1);
  // WAIT_SYNC is only left through a wrap to index 0, so the first load never
  // consumes a word and no extra state term is needed here.
  assign load_data_s = skut40 & (next_idx_s != {IDX_W{1'b0}});
  assign din_ready   = load_data_s & din_valid;

  // Next-state and datapath decode; a load on skut40 overrides any slot.
  always_comb begin
    state_s  = state_r;
    shreg_s  = shreg_r;
    bitcnt_s = bitcnt_r;
    sdata_s  = sdata_r;
    frame_s  = frame_r;
    idx_s    = idx_r;
    uf_s     = uf_r;
`ifdef MBR_PARITY_EN
    par_s    = par_r;
`endif

    if (underflow_clr) begin
      uf_s = 1'b0;
    end else begin
      uf_s = uf_r;
    end

    if (skut40) begin
      idx_s    = next_idx_s;
      bitcnt_s = {BCNT_W{1'b0}};
      state_s  = SHIFT;
      if (!load_data_s) begin
        shreg_s = SYNC_WORD;
        frame_s = 1'b1;
      end else if (din_valid) begin
        shreg_s = din;
        frame_s = 1'b0;
      end else begin
        shreg_s = FILL_WORD;
        frame_s = 1'b0;
        uf_s    = 1'b1;
      end
`ifdef MBR_PARITY_EN
      par_s = odd_parity(shreg_s);
`endif
    end else begin
      case (state_r)
        WAIT_SYNC: begin
          sdata_s = IDLE_BIT;
        end
        SHIFT: begin
          if (slot_s) begin
`ifdef MBR_PARITY_EN
            if (bitcnt_r == BCNT_W'(WORD_W)) begin
              sdata_s = par_r;
              state_s = PAD;
            end else begin
              sdata_s  = shreg_r[WORD_W-1];
              shreg_s  = {shreg_r[WORD_W-2:0], 1'b0};
              bitcnt_s = bitcnt_r + BCNT_W'(1);
            end
`else
            sdata_s  = shreg_r[WORD_W-1];
            shreg_s  = {shreg_r[WORD_W-2:0], 1'b0};
            bitcnt_s = bitcnt_r + BCNT_W'(1);
            if (bitcnt_r == BCNT_W'(WORD_W - 1)) begin
              state_s = PAD;
            end else begin
              state_s = SHIFT;
            end
`endif
          end else begin
            sdata_s = sdata_r;
          end
        end
        PAD: begin
          if (slot_s) begin
            sdata_s = IDLE_BIT;
          end else begin
            sdata_s = sdata_r;
          end
        end
        default: begin
          state_s = WAIT_SYNC;
          sdata_s = IDLE_BIT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= WAIT_SYNC;
      shreg_r  <= {WORD_W{1'b0}};
      bitcnt_r <= {BCNT_W{1'b0}};
      sdata_r  <= IDLE_BIT;
      frame_r  <= 1'b0;
      idx_r    <= IDX_W'(FRAME_WORDS - 1);
      uf_r     <= 1'b0;
`ifdef MBR_PARITY_EN
      par_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      shreg_r  <= shreg_s;
      bitcnt_r <= bitcnt_s;
      sdata_r  <= sdata_s;
      frame_r  <= frame_s;
      idx_r    <= idx_s;
      uf_r     <= uf_s;
`ifdef MBR_PARITY_EN
      par_r    <= par_s;
`endif
    end
  end

  assign sdata_o     = sdata_r;
  assign frame_o     = frame_r;
  assign word_idx_o  = idx_r;
  assign underflow_o = uf_r;

endmodule

// File: tb/tb_mbr_word_serializer.sv
// Directed, table-driven bench for mbr_word_serializer.
module tb_mbr_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i320 = 1'b0;
  logic        skut40 = 1'b0;
  logic [11:0] din = 12'h000;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        underflow_clr = 1'b0;
  logic        sdata_o;
  logic        frame_o;
  logic [4:0]  word_idx_o;
  logic        underflow_o;

  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;

  typedef struct {
    logic        valid;
    logic [11:0] din;
    logic        clr;
    logic [4:0]  idx;
    logic        frame;
    logic        uf;
    logic [11:0] word;
    int          ready;
    int          pad;
  } vec_t;

  vec_t tbl[5];

  mbr_word_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .i320          (i320),
    .skut40        (skut40),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .underflow_clr (underflow_clr),
    .sdata_o       (sdata_o),
    .frame_o       (frame_o),
    .word_idx_o    (word_idx_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (din_ready) ready_cnt <= ready_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_slot();
    i320 = 1'b1;
    tick();
    i320 = 1'b0;
    tick();
  endtask

  task automatic pulse_skut();
    skut40 = 1'b1;
    tick();
    skut40 = 1'b0;
  endtask

  initial begin
    int r0;
    int bad;
    logic [11:0] got;

    tbl[0] = '{valid: 1'b0, din: 12'h000, clr: 1'b0, idx: 5'd0, frame: 1'b1, uf: 1'b0, word: 12'hE2B, ready: 0, pad: 29};
    tbl[1] = '{valid: 1'b1, din: 12'hA5C, clr: 1'b0, idx: 5'd1, frame: 1'b0, uf: 1'b0, word: 12'hA5C, ready: 1, pad: 2};
    tbl[2] = '{valid: 1'b0, din: 12'hFFF, clr: 1'b0, idx: 5'd2, frame: 1'b0, uf: 1'b1, word: 12'h000, ready: 0, pad: 2};
    tbl[3] = '{valid: 1'b1, din: 12'h3C7, clr: 1'b0, idx: 5'd3, frame: 1'b0, uf: 1'b1, word: 12'h3C7, ready: 1, pad: 2};
    tbl[4] = '{valid: 1'b1, din: 12'h5A1, clr: 1'b1, idx: 5'd4, frame: 1'b0, uf: 1'b0, word: 12'h5A1, ready: 1, pad: 1};

    // Reset and idle slots before the first boundary
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_sdata", 32'(sdata_o), 32'd1);
    chk("rst_frame", 32'(frame_o), 32'd0);
    chk("rst_idx", 32'(word_idx_o), 32'd31);
    chk("rst_uf", 32'(underflow_o), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      do_slot();
      if (sdata_o !== 1'b1) bad = bad + 1;
    end
    chk("presync_sdata", 32'(bad), 32'd0);
    chk("presync_ready", 32'(ready_cnt), 32'd0);
    chk("presync_idx", 32'(word_idx_o), 32'd31);

    // Table: one word per record
    for (int v = 0; v < 5; v++) begin
      din = tbl[v].din;
      din_valid = tbl[v].valid;
      if (tbl[v].clr) begin
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
      end
      r0 = ready_cnt;
      pulse_skut();
      chk($sformatf("v%0d_idx", v), 32'(word_idx_o), 32'(tbl[v].idx));
      chk($sformatf("v%0d_frame", v), 32'(frame_o), 32'(tbl[v].frame));
      chk($sformatf("v%0d_uf", v), 32'(underflow_o), 32'(tbl[v].uf));
      chk($sformatf("v%0d_ready", v), 32'(ready_cnt - r0), 32'(tbl[v].ready));
      din_valid = 1'b0;
      for (int b = 0; b < 12; b++) begin
        do_slot();
        got[11-b] = sdata_o;
      end
      chk($sformatf("v%0d_word", v), 32'(got), 32'(tbl[v].word));
`ifdef MBR_PARITY_EN
      do_slot();
      chk($sformatf("v%0d_par", v), 32'(sdata_o), 32'(~(^tbl[v].word)));
`endif
      bad = 0;
      for (int p = 0; p < tbl[v].pad; p++) begin
        do_slot();
        if (sdata_o !== 1'b1) bad = bad + 1;
      end
      chk($sformatf("v%0d_pad", v), 32'(bad), 32'd0);
    end

    // Rest of the frame, wrap, then a full frame of ready pulses
    din = 12'h123;
    din_valid = 1'b1;
    for (int k = 5; k < 32; k++) begin
      pulse_skut();
      chk($sformatf("walk_idx%0d", k), 32'(word_idx_o), 32'(k));
    end
    pulse_skut();
    chk("wrap_idx", 32'(word_idx_o), 32'd0);
    chk("wrap_frame", 32'(frame_o), 32'd1);
    r0 = ready_cnt;
    for (int k = 1; k < 32; k++) pulse_skut();
    chk("frame_last_idx", 32'(word_idx_o), 32'd31);
    pulse_skut();
    chk("frame2_idx", 32'(word_idx_o), 32'd0);
    chk("frame2_frame", 32'(frame_o), 32'd1);
    chk("frame_ready_cnt", 32'(ready_cnt - r0), 32'd31);

    // Early boundary coinciding with a slot: slot dropped, sdata held
    for (int b = 0; b < 3; b++) begin
      do_slot();
      chk($sformatf("sync_bit%0d", b), 32'(sdata_o), 32'd1);
    end
    din = 12'h000;
    din_valid = 1'b1;
    i320 = 1'b1;
    skut40 = 1'b1;
    tick();
    skut40 = 1'b0;
    i320 = 1'b0;
    din_valid = 1'b0;
    chk("coinc_sdata", 32'(sdata_o), 32'd1);
    chk("coinc_idx", 32'(word_idx_o), 32'd1);
    tick();
    do_slot();
    chk("coinc_next_bit", 32'(sdata_o), 32'd0);

    // Underflow clear, then set beating clear in the same cycle
    pulse_skut();
    chk("uf_set", 32'(underflow_o), 32'd1);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("uf_clr", 32'(underflow_o), 32'd0);
    underflow_clr = 1'b1;
    pulse_skut();
    underflow_clr = 1'b0;
    chk("uf_set_wins", 32'(underflow_o), 32'd1);
    chk("uf_set_idx", 32'(word_idx_o), 32'd3);
    do_slot();
    chk("fill_bit", 32'(sdata_o), 32'd0);

    // Reset mid-word
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_sdata", 32'(sdata_o), 32'd1);
    chk("mid_rst_frame", 32'(frame_o), 32'd0);
    chk("mid_rst_idx", 32'(word_idx_o), 32'd31);
    chk("mid_rst_uf", 32'(underflow_o), 32'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      do_slot();
      if (sdata_o !== 1'b1) bad = bad + 1;
    end
    chk("mid_rst_wait", 32'(bad), 32'd0);
    din_valid = 1'b1;
    r0 = ready_cnt;
    pulse_skut();
    din_valid = 1'b0;
    chk("resync_frame", 32'(frame_o), 32'd1);
    chk("resync_ready", 32'(ready_cnt - r0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
